// File: rtl/zsdram_fb_client.sv
// zsdram_fb_client
//   Requester-side client of the SDRAM read/write arbiter. Incoming pixels are
//   buffered in a write FIFO and flushed to SDRAM. The display frame is
//   prefetched into a read FIFO for the TFT pixel pipeline. At most one arbiter
//   request is outstanding. Frame addressing is linear and wraps after
//   BASE_ADDR+FRAME_WORDS-1.
//
//   Optional feature macro: ZSDRAM_FB_UNDERRUN_CNT_EN
//     defined     : oUnderrun_Cnt counts cycles where the display asks for a
//                   pixel while the read FIFO is empty (saturating, cleared by
//                   rst or iFrame_Sync)
//     not defined : oUnderrun_Cnt is tied to zero
//
// Ports
//   clk, rst                 system clock, synchronous active-high reset
//   en                       0 blocks new requests; an outstanding one completes
//   iFrame_Sync              restart both address counters, flush read FIFO
//   iWr_Pix_*/oWr_Pix_Ready  write pixel stream into the write FIFO
//   iRd_Pix_Ready/oRd_Pix_*  display side of the read FIFO (fall-through head)
//   oRd_Req/oRd_Addr         read request to the arbiter
//   iRd_Done/iRd_Data        read completion pulse and returned word
//   oWr_Req/oWr_Addr/oWr_Data write request to the arbiter
//   iWr_Done                 write completion pulse
//   oUnderrun_Cnt            display underrun count
module zsdram_fb_client #(
  parameter int unsigned FRAME_WORDS = 130560,
  parameter logic [23:0] BASE_ADDR   = 24'h0,
  parameter int unsigned FIFO_AW     = 4,
  parameter int unsigned RD_LOW_WM   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        iFrame_Sync,
  input  logic        iWr_Pix_Valid,
  input  logic [15:0] iWr_Pix_Data,
  output logic        oWr_Pix_Ready,
  input  logic        iRd_Pix_Ready,
  output logic        oRd_Pix_Valid,
  output logic [15:0] oRd_Pix_Data,
  output logic        oRd_Req,
  output logic [23:0] oRd_Addr,
  input  logic        iRd_Done,
  input  logic [15:0] iRd_Data,
  output logic        oWr_Req,
  output logic [23:0] oWr_Addr,
  output logic [15:0] oWr_Data,
  input  logic        iWr_Done,
  output logic [15:0] oUnderrun_Cnt
);

  localparam int unsigned DEPTH = 1 << FIFO_AW;

  typedef logic [FIFO_AW-1:0] ptr_t;
  typedef logic [FIFO_AW:0]   cnt_t;

  localparam cnt_t        L_DEPTH   = cnt_t'(DEPTH);
  localparam cnt_t        L_LOW_WM  = cnt_t'(RD_LOW_WM);
  localparam logic [23:0] LAST_ADDR = 24'(BASE_ADDR + FRAME_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_WR_WAIT
  } state_t;

  function automatic logic [23:0] f_next_addr(input logic [23:0] a);
    return (a == LAST_ADDR) ? BASE_ADDR : a + 24'd1;
  endfunction

  state_t      r_state, w_state_nxt;
  logic        w_issue_rd, w_issue_wr, w_rd_done, w_wr_done;

  // read FIFO
  logic [15:0] r_rd_mem [DEPTH];
  ptr_t        r_rd_wptr, r_rd_rptr;
  cnt_t        r_rd_cnt;
  logic        w_rd_push, w_rd_pop;

  // write FIFO
  logic [15:0] r_wr_mem [DEPTH];
  ptr_t        r_wr_wptr, r_wr_rptr;
  cnt_t        r_wr_cnt;
  logic        w_wr_push, w_wr_pop;

  // address counters and sync bookkeeping
  logic [23:0] r_rd_addr, r_wr_addr;
  logic        r_rd_discard, r_wr_restart;

  // registered request outputs
  logic        r_rd_req, r_wr_req;
  logic [23:0] r_rd_addr_o, r_wr_addr_o;
  logic [15:0] r_wr_data_o;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue_rd  = 1'b0;
    w_issue_wr  = 1'b0;
    w_rd_done   = 1'b0;
    w_wr_done   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (en) begin
          // low read level preempts writes; otherwise drain writes, then top up reads
          if (r_rd_cnt <= L_LOW_WM && r_rd_cnt < L_DEPTH) w_issue_rd = 1'b1;
          else if (r_wr_cnt != '0)                        w_issue_wr = 1'b1;
          else if (r_rd_cnt < L_DEPTH)                    w_issue_rd = 1'b1;
          if (w_issue_rd)      w_state_nxt = ST_RD_WAIT;
          else if (w_issue_wr) w_state_nxt = ST_WR_WAIT;
        end
      end
      ST_RD_WAIT: begin
        if (iRd_Done) begin
          w_rd_done   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_WR_WAIT: begin
        if (iWr_Done) begin
          w_wr_done   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------- read FIFO
  // A word returned for a read that was in flight across a frame sync belongs
  // to the old frame and is dropped.
  assign w_rd_push     = w_rd_done && !r_rd_discard && !iFrame_Sync;
  assign oRd_Pix_Valid = (r_rd_cnt != '0);
  assign w_rd_pop      = iRd_Pix_Ready && oRd_Pix_Valid;

  always_ff @(posedge clk) begin
    if (rst || iFrame_Sync) begin
      r_rd_wptr <= '0;
      r_rd_rptr <= '0;
      r_rd_cnt  <= '0;
    end else begin
      if (w_rd_push) r_rd_wptr <= r_rd_wptr + ptr_t'(1);
      if (w_rd_pop)  r_rd_rptr <= r_rd_rptr + ptr_t'(1);
      case ({w_rd_push, w_rd_pop})
        2'b10:   r_rd_cnt <= r_rd_cnt + cnt_t'(1);
        2'b01:   r_rd_cnt <= r_rd_cnt - cnt_t'(1);
        default: r_rd_cnt <= r_rd_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_rd_push) r_rd_mem[r_rd_wptr] <= iRd_Data;
  end

  always_comb begin
    oRd_Pix_Data = '0;
    if (oRd_Pix_Valid) oRd_Pix_Data = r_rd_mem[r_rd_rptr];
  end

  // ---------------------------------------------------------------- write FIFO
  assign oWr_Pix_Ready = (r_wr_cnt != L_DEPTH);
  assign w_wr_push     = iWr_Pix_Valid && oWr_Pix_Ready;
  assign w_wr_pop      = w_wr_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_wptr <= '0;
      r_wr_rptr <= '0;
      r_wr_cnt  <= '0;
    end else begin
      if (w_wr_push) r_wr_wptr <= r_wr_wptr + ptr_t'(1);
      if (w_wr_pop)  r_wr_rptr <= r_wr_rptr + ptr_t'(1);
      case ({w_wr_push, w_wr_pop})
        2'b10:   r_wr_cnt <= r_wr_cnt + cnt_t'(1);
        2'b01:   r_wr_cnt <= r_wr_cnt - cnt_t'(1);
        default: r_wr_cnt <= r_wr_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_push) r_wr_mem[r_wr_wptr] <= iWr_Pix_Data;
  end

  // ---------------------------------------------------------------- addresses
  // The request address is latched at issue, so a sync during a wait can move
  // the counters without disturbing the address the arbiter is working on.
  // The discard/restart flags remember such a sync until the matching Done.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_addr    <= BASE_ADDR;
      r_wr_addr    <= BASE_ADDR;
      r_rd_discard <= 1'b0;
      r_wr_restart <= 1'b0;
    end else begin
      if (iFrame_Sync)    r_rd_addr <= BASE_ADDR;
      else if (w_rd_push) r_rd_addr <= f_next_addr(r_rd_addr);

      if (iFrame_Sync)                     r_wr_addr <= BASE_ADDR;
      else if (w_wr_done && !r_wr_restart) r_wr_addr <= f_next_addr(r_wr_addr);

      r_rd_discard <= (r_state == ST_RD_WAIT) && !iRd_Done && (r_rd_discard || iFrame_Sync);
      r_wr_restart <= (r_state == ST_WR_WAIT) && !iWr_Done && (r_wr_restart || iFrame_Sync);
    end
  end

  // ---------------------------------------------------------------- requests
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_req    <= 1'b0;
      r_wr_req    <= 1'b0;
      r_rd_addr_o <= '0;
      r_wr_addr_o <= '0;
      r_wr_data_o <= '0;
    end else begin
      if (w_issue_rd) begin
        r_rd_req    <= 1'b1;
        r_rd_addr_o <= iFrame_Sync ? BASE_ADDR : r_rd_addr;
      end else if (w_rd_done) begin
        r_rd_req    <= 1'b0;
      end

      if (w_issue_wr) begin
        r_wr_req    <= 1'b1;
        r_wr_addr_o <= iFrame_Sync ? BASE_ADDR : r_wr_addr;
        r_wr_data_o <= r_wr_mem[r_wr_rptr];
      end else if (w_wr_done) begin
        r_wr_req    <= 1'b0;
      end
    end
  end

  assign oRd_Req  = r_rd_req;
  assign oRd_Addr = r_rd_addr_o;
  assign oWr_Req  = r_wr_req;
  assign oWr_Addr = r_wr_addr_o;
  assign oWr_Data = r_wr_data_o;

  // ---------------------------------------------------------------- underrun
`ifdef ZSDRAM_FB_UNDERRUN_CNT_EN
  logic [15:0] r_underrun_cnt;

  always_ff @(posedge clk) begin
    if (rst || iFrame_Sync)
      r_underrun_cnt <= '0;
    else if (iRd_Pix_Ready && !oRd_Pix_Valid && r_underrun_cnt != '1)
      r_underrun_cnt <= r_underrun_cnt + 16'd1;
  end

  assign oUnderrun_Cnt = r_underrun_cnt;
`else
  assign oUnderrun_Cnt = '0;
`endif

endmodule

// File: tb/tb_zsdram_fb_client.sv
// Testbench for zsdram_fb_client: a behavioural arbiter answers requests after
// a programmable latency; write pixels and returned read words are tracked in
// scoreboard queues and compared as the DUT issues writes / presents pixels.
module tb_zsdram_fb_client;

  localparam int unsigned FW   = 4;
  localparam logic [23:0] BASE = 24'h000100;
`ifdef ZSDRAM_FB_UNDERRUN_CNT_EN
  localparam int unsigned UR_EXP = 7;
`else
  localparam int unsigned UR_EXP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst, en, iFrame_Sync;
  logic        iWr_Pix_Valid;
  logic [15:0] iWr_Pix_Data;
  logic        oWr_Pix_Ready;
  logic        iRd_Pix_Ready;
  logic        oRd_Pix_Valid;
  logic [15:0] oRd_Pix_Data;
  logic        oRd_Req;
  logic [23:0] oRd_Addr;
  logic        iRd_Done;
  logic [15:0] iRd_Data;
  logic        oWr_Req;
  logic [23:0] oWr_Addr;
  logic [15:0] oWr_Data;
  logic        iWr_Done;
  logic [15:0] oUnderrun_Cnt;

  zsdram_fb_client #(
    .FRAME_WORDS (FW),
    .BASE_ADDR   (BASE),
    .FIFO_AW     (4),
    .RD_LOW_WM   (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .iFrame_Sync   (iFrame_Sync),
    .iWr_Pix_Valid (iWr_Pix_Valid),
    .iWr_Pix_Data  (iWr_Pix_Data),
    .oWr_Pix_Ready (oWr_Pix_Ready),
    .iRd_Pix_Ready (iRd_Pix_Ready),
    .oRd_Pix_Valid (oRd_Pix_Valid),
    .oRd_Pix_Data  (oRd_Pix_Data),
    .oRd_Req       (oRd_Req),
    .oRd_Addr      (oRd_Addr),
    .iRd_Done      (iRd_Done),
    .iRd_Data      (iRd_Data),
    .oWr_Req       (oWr_Req),
    .oWr_Addr      (oWr_Addr),
    .oWr_Data      (oWr_Data),
    .iWr_Done      (iWr_Done),
    .oUnderrun_Cnt (oUnderrun_Cnt)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [15:0] rd_q[$];     // words expected at the display, in order
  logic [15:0] wr_q[$];     // pixels expected to be written, in order
  int          op_log[$];   // 0 = read request, 1 = write request
  logic [23:0] addr_log[$]; // read request addresses

  logic [23:0] exp_rd_addr = BASE;
  logic [23:0] exp_wr_addr = BASE;
  int          lat = 5;
  int          rd_seq = 0;
  logic        arb_busy = 1'b0;
  logic        drop_next_rd = 1'b0;
  logic        no_hold = 1'b0;
  logic        spur_rd = 1'b0;
  logic        spur_wr = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] next_addr(input logic [23:0] a);
    return BASE + 24'(((32'(a) - 32'(BASE)) + 1) % FW);
  endfunction

  // ------------------------------------------------------------ arbiter model
  initial begin : arbiter
    logic [23:0] a;
    logic [15:0] d;
    iRd_Done = 1'b0;
    iWr_Done = 1'b0;
    iRd_Data = '0;
    forever begin
      @(posedge clk); #1;
      if (spur_rd) begin
        iRd_Done = 1'b1; iRd_Data = 16'hDEAD;
        @(posedge clk); #1;
        iRd_Done = 1'b0; iRd_Data = '0; spur_rd = 1'b0;
      end else if (spur_wr) begin
        iWr_Done = 1'b1;
        @(posedge clk); #1;
        iWr_Done = 1'b0; spur_wr = 1'b0;
      end else if (oRd_Req && oWr_Req) begin
        check("one_outstanding", 32'({oRd_Req, oWr_Req}), 32'd0);
      end else if (oRd_Req) begin
        arb_busy = 1'b1;
        a = oRd_Addr;
        op_log.push_back(0);
        addr_log.push_back(a);
        check("rd_addr", 32'(a), 32'(exp_rd_addr));
        repeat (lat - 1) @(posedge clk);
        #1;
        if (!no_hold) check("rd_hold", 32'({oRd_Req, oRd_Addr}), 32'({1'b1, a}));
        d = {4'hC, 12'(rd_seq)};
        rd_seq++;
        iRd_Done = 1'b1; iRd_Data = d;
        @(posedge clk); #1;
        iRd_Done = 1'b0; iRd_Data = '0;
        if (!no_hold) check("rd_req_low_after_done", 32'(oRd_Req), 32'd0);
        if (drop_next_rd) drop_next_rd = 1'b0;
        else begin
          rd_q.push_back(d);
          exp_rd_addr = next_addr(exp_rd_addr);
        end
        arb_busy = 1'b0;
      end else if (oWr_Req) begin
        arb_busy = 1'b1;
        a = oWr_Addr;
        op_log.push_back(1);
        check("wr_addr", 32'(a), 32'(exp_wr_addr));
        check("wr_q_nonempty", 32'(wr_q.size() > 0), 32'd1);
        if (wr_q.size() > 0) check("wr_data", 32'(oWr_Data), 32'(wr_q[0]));
        repeat (lat - 1) @(posedge clk);
        #1;
        check("wr_hold", 32'({oWr_Req, oWr_Addr}), 32'({1'b1, a}));
        iWr_Done = 1'b1;
        @(posedge clk); #1;
        iWr_Done = 1'b0;
        check("wr_req_low_after_done", 32'(oWr_Req), 32'd0);
        if (wr_q.size() > 0) void'(wr_q.pop_front());
        exp_wr_addr = next_addr(exp_wr_addr);
        arb_busy = 1'b0;
      end
    end
  end

  // ------------------------------------------------------------ helpers
  task automatic quiesce();
    int t = 0;
    en = 1'b0;
    repeat (3) @(negedge clk);
    while ((arb_busy || oRd_Req || oWr_Req) && t < 200) begin
      @(negedge clk); t++;
    end
    check("quiesce", 32'({arb_busy, oRd_Req, oWr_Req}), 32'd0);
  endtask

  task automatic push_pix(input logic [15:0] d);
    int t = 0;
    @(negedge clk);
    while (!oWr_Pix_Ready && t < 300) begin
      @(negedge clk); t++;
    end
    check("push_ready", 32'(oWr_Pix_Ready), 32'd1);
    iWr_Pix_Valid = 1'b1;
    iWr_Pix_Data  = d;
    if (oWr_Pix_Ready) wr_q.push_back(d);
    @(negedge clk);
    iWr_Pix_Valid = 1'b0;
  endtask

  task automatic pop_pix(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      @(negedge clk);
      iRd_Pix_Ready = 1'b0;
      while (!oRd_Pix_Valid && t < 200) begin
        @(negedge clk); t++;
      end
      check("pop_valid", 32'(oRd_Pix_Valid), 32'd1);
      if (oRd_Pix_Valid) begin
        check("rd_q_nonempty", 32'(rd_q.size() > 0), 32'd1);
        if (rd_q.size() > 0) check("rd_pix", 32'(oRd_Pix_Data), 32'(rd_q.pop_front()));
        iRd_Pix_Ready = 1'b1;
      end
    end
    @(negedge clk);
    iRd_Pix_Ready = 1'b0;
  endtask

  task automatic frame_sync();
    @(negedge clk);
    iFrame_Sync = 1'b1;
    @(negedge clk);
    iFrame_Sync = 1'b0;
    rd_q.delete();
    exp_rd_addr = BASE;
    exp_wr_addr = BASE;
  endtask

  task automatic wait_rd_req(input string tag);
    int t = 0;
    while (!oRd_Req && t < 100) begin
      @(negedge clk); t++;
    end
    check(tag, 32'(oRd_Req), 32'd1);
  endtask

  task automatic wait_rd_level(input int lvl);
    int t = 0;
    while (rd_q.size() < lvl && t < 3000) begin
      @(negedge clk); t++;
    end
    check("rd_level", 32'(rd_q.size()), 32'(lvl));
  endtask

  task automatic wait_wr_drain();
    int t = 0;
    while (wr_q.size() > 0 && t < 3000) begin
      @(negedge clk); t++;
    end
    check("wr_drain", 32'(wr_q.size()), 32'd0);
  endtask

  // ------------------------------------------------------------ watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_errors + 1, n_checks + 1);
    $fatal(1);
  end

  // ------------------------------------------------------------ main sequence
  initial begin
    logic [23:0] wrap_exp [6];
    int lvl;
    wrap_exp = '{24'd0, 24'd1, 24'd2, 24'd3, 24'd0, 24'd1};

    rst = 1'b1; en = 1'b0; iFrame_Sync = 1'b0;
    iWr_Pix_Valid = 1'b0; iWr_Pix_Data = '0; iRd_Pix_Ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // reset state
    check("rst_wr_ready",  32'(oWr_Pix_Ready), 32'd1);
    check("rst_rd_valid",  32'(oRd_Pix_Valid), 32'd0);
    check("rst_rd_data",   32'(oRd_Pix_Data),  32'd0);
    check("rst_reqs",      32'({oRd_Req, oWr_Req}), 32'd0);
    check("rst_rd_addr",   32'(oRd_Addr), 32'd0);
    check("rst_wr_addr",   32'(oWr_Addr), 32'd0);
    check("rst_wr_data",   32'(oWr_Data), 32'd0);
    check("rst_underrun",  32'(oUnderrun_Cnt), 32'd0);

    // fill the read FIFO; addresses wrap every FW words
    en = 1'b1;
    wait_rd_level(16);
    repeat (10) @(negedge clk);
    check("full_no_read", 32'(oRd_Req), 32'd0);
    quiesce();
    check("full_valid", 32'(oRd_Pix_Valid), 32'd1);
    for (int i = 0; i < 6; i++)
      check("wrap_addr", 32'(addr_log[i]), 32'(BASE + wrap_exp[i]));

    // three writes with read FIFO full
    push_pix(16'hA001); push_pix(16'hA002); push_pix(16'hA003);
    repeat (3) @(negedge clk);
    check("en0_no_issue", 32'({oRd_Req, oWr_Req}), 32'd0);
    op_log.delete();
    en = 1'b1;
    wait_wr_drain();
    quiesce();
    check("t1_ops", 32'(op_log.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("t1_op_is_write", 32'((op_log.size() > i) ? op_log[i] : -1), 32'd1);

    // read level 2 with a pending write: reads go first until above the mark
    push_pix(16'hB001);
    pop_pix(14);
    op_log.delete();
    en = 1'b1;
    wait_wr_drain();
    check("lvl2_first_read",  32'((op_log.size() > 0) ? op_log[0] : -1), 32'd0);
    check("lvl2_write_at_4",  32'((op_log.size() > 3) ? op_log[3] : -1), 32'd1);
    wait_rd_level(16);
    quiesce();

    // read level 10 with a pending write: write goes first
    push_pix(16'hB002);
    pop_pix(6);
    op_log.delete();
    en = 1'b1;
    wait_wr_drain();
    check("lvl10_first_write", 32'((op_log.size() > 0) ? op_log[0] : -1), 32'd1);
    wait_rd_level(16);
    quiesce();

    // frame sync while a read is in flight
    pop_pix(3);
    lat = 8;
    en = 1'b1;
    @(negedge clk);
    wait_rd_req("t4_req");
    en = 1'b0;
    drop_next_rd = 1'b1;
    frame_sync();
    check("t4_flush", 32'(oRd_Pix_Valid), 32'd0);
    quiesce();
    check("t4_drop_consumed", 32'(drop_next_rd), 32'd0);
    check("t4_dropped", 32'(oRd_Pix_Valid), 32'd0);
    lat = 5;
    en = 1'b1;
    @(negedge clk);
    wait_rd_req("t4_req2");
    check("t4_next_addr", 32'(oRd_Addr), 32'(BASE));
    wait_rd_level(16);
    quiesce();

    // spurious Done pulses while idle
    lvl = rd_q.size();
    spur_rd = 1'b1;
    repeat (4) @(negedge clk);
    check("spur_rd_sent", 32'(spur_rd), 32'd0);
    spur_wr = 1'b1;
    repeat (4) @(negedge clk);
    check("spur_wr_sent", 32'(spur_wr), 32'd0);
    pop_pix(lvl);
    check("spur_no_push", 32'(oRd_Pix_Valid), 32'd0);

    // en dropped while in RD_WAIT: the read still completes
    lat = 6;
    en = 1'b1;
    @(negedge clk);
    wait_rd_req("en0_req");
    en = 1'b0;
    quiesce();
    check("en0_completed", 32'(rd_q.size()), 32'd1);
    check("en0_valid", 32'(oRd_Pix_Valid), 32'd1);
    pop_pix(1);
    lat = 5;
    push_pix(16'hC001);
    en = 1'b1;
    wait_wr_drain();
    wait_rd_level(16);
    quiesce();

    // underrun counter
    pop_pix(rd_q.size());
    frame_sync();
    check("ur_clear", 32'(oUnderrun_Cnt), 32'd0);
    iRd_Pix_Ready = 1'b1;
    repeat (7) @(negedge clk);
    iRd_Pix_Ready = 1'b0;
    check("ur_count", 32'(oUnderrun_Cnt), 32'(UR_EXP));
    frame_sync();
    check("ur_sync_clear", 32'(oUnderrun_Cnt), 32'd0);

    // write FIFO full boundary
    for (int i = 0; i < 16; i++) push_pix(16'hD000 + 16'(i));
    check("wr_full", 32'(oWr_Pix_Ready), 32'd0);
    en = 1'b1;
    wait_wr_drain();
    check("wr_not_full", 32'(oWr_Pix_Ready), 32'd1);
    quiesce();
    pop_pix(rd_q.size());

    // reset with a read in flight
    lat = 6;
    en = 1'b1;
    @(negedge clk);
    wait_rd_req("rst_mid_req");
    no_hold = 1'b1;
    drop_next_rd = 1'b1;
    rst = 1'b1;
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    rd_q.delete();
    wr_q.delete();
    exp_rd_addr = BASE;
    exp_wr_addr = BASE;
    check("rst_mid_req_low", 32'(oRd_Req), 32'd0);
    check("rst_mid_addr",    32'(oRd_Addr), 32'd0);
    quiesce();
    no_hold = 1'b0;
    check("rst_mid_done_ignored", 32'(oRd_Pix_Valid), 32'd0);
    lat = 5;
    en = 1'b1;
    @(negedge clk);
    wait_rd_req("rst_mid_req2");
    check("rst_mid_next_addr", 32'(oRd_Addr), 32'(BASE));
    quiesce();
    pop_pix(rd_q.size());

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
